// File: rtl/line_burst_adapter_if.sv
// Signal bundle between the cache RAM-side port, line_burst_adapter and main memory.
// master = cache/memory environment, slave = the adapter itself.
interface line_burst_adapter_if #(
  parameter int s_line  = 256,
  parameter int s_burst = 64
);
  logic [s_line-1:0]  line_i;
  logic [s_line-1:0]  line_o;
  logic [31:0]        address_i;
  logic               read_i;
  logic               write_i;
  logic               resp_o;
  logic [s_burst-1:0] burst_i;
  logic [s_burst-1:0] burst_o;
  logic [31:0]        address_o;
  logic               read_o;
  logic               write_o;
  logic               resp_i;

  modport master (
    output line_i, address_i, read_i, write_i, burst_i, resp_i,
    input  line_o, resp_o, burst_o, address_o, read_o, write_o
  );

  modport slave (
    input  line_i, address_i, read_i, write_i, burst_i, resp_i,
    output line_o, resp_o, burst_o, address_o, read_o, write_o
  );
endinterface

// File: rtl/line_burst_adapter.sv
// Converts one cacheline read/write into BEATS sequential memory beats, one transaction at a time.
// Optional LINE_ADAPTER_STATS_EN adds saturating completed-read/write counters rd_count/wr_count.
module line_burst_adapter #(
  parameter int s_offset = 5,
  parameter int s_line   = 8 * 2**s_offset,
  parameter int s_burst  = 64,
  parameter int BEATS    = s_line / s_burst
) (
  input  logic clk,
  input  logic rst,
  line_burst_adapter_if.slave bus
`ifdef LINE_ADAPTER_STATS_EN
  ,
  output logic [31:0] rd_count,
  output logic [31:0] wr_count
`endif
);
  localparam int CW = (BEATS > 1) ? $clog2(BEATS) : 1;
  localparam logic [CW-1:0] LAST = CW'(BEATS - 1);
  localparam logic [31:0] ADDR_MASK = ~((32'd1 << s_offset) - 32'd1);

  typedef enum logic [1:0] {IDLE, RD, WR, DONE} state_t;

  state_t            state, state_next;
  logic [CW-1:0]     count;
  logic [s_line-1:0] line_buf;
  logic [s_line-1:0] line_q;
  logic [31:0]       addr_q;
  logic              read_q, write_q, resp_q;
  logic              last_beat;

  assign last_beat = bus.resp_i && (count == LAST);

  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= IDLE;
      read_q  <= 1'b0;
      write_q <= 1'b0;
      resp_q  <= 1'b0;
    end else begin
      state   <= state_next;
      read_q  <= (state_next == RD);
      write_q <= (state_next == WR);
      resp_q  <= (state_next == DONE);
    end
  end

  // Write wins when both requests are seen in IDLE.
  always_comb begin
    state_next = state;
    case (state)
      IDLE: begin
        if (bus.write_i)     state_next = WR;
        else if (bus.read_i) state_next = RD;
      end
      RD, WR: if (last_beat) state_next = DONE;
      DONE:   state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // count holds at the final beat; only a new transaction returns it to zero.
  always_ff @(posedge clk) begin
    if (rst) begin
      count    <= '0;
      line_buf <= '0;
      line_q   <= '0;
      addr_q   <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (bus.write_i || bus.read_i) begin
            addr_q   <= bus.address_i & ADDR_MASK;
            line_buf <= bus.line_i;
            count    <= '0;
          end
        end
        RD: begin
          if (bus.resp_i) begin
            line_q[s_burst*count +: s_burst] <= bus.burst_i;
            if (count != LAST) count <= count + 1'b1;
          end
        end
        WR: begin
          if (bus.resp_i && (count != LAST)) count <= count + 1'b1;
        end
        default: ;
      endcase
    end
  end

  assign bus.line_o    = line_q;
  assign bus.address_o = addr_q;
  assign bus.read_o    = read_q;
  assign bus.write_o   = write_q;
  assign bus.resp_o    = resp_q;
  assign bus.burst_o   = line_buf[s_burst*count +: s_burst];

`ifdef LINE_ADAPTER_STATS_EN
  logic is_write;

  // Aborted bursts never reach DONE, so only completed transactions are counted.
  always_ff @(posedge clk) begin
    if (rst) begin
      is_write <= 1'b0;
      rd_count <= '0;
      wr_count <= '0;
    end else begin
      if (state == IDLE) begin
        if (bus.write_i)     is_write <= 1'b1;
        else if (bus.read_i) is_write <= 1'b0;
      end
      if (state == DONE) begin
        if (is_write) begin
          if (wr_count != 32'hFFFF_FFFF) wr_count <= wr_count + 32'd1;
        end else begin
          if (rd_count != 32'hFFFF_FFFF) rd_count <= rd_count + 32'd1;
        end
      end
    end
  end
`endif
endmodule

// File: tb/tb_line_burst_adapter.sv
// Self-checking bench for line_burst_adapter: table of whole-line transactions plus a reset-abort sequence.
// Define LINE_ADAPTER_STATS_EN to also check the completion counters.
module tb_line_burst_adapter;
  logic clk;
  logic rst;
  int   checks;
  int   errors;

  line_burst_adapter_if #(.s_line(256), .s_burst(64)) bus ();

`ifdef LINE_ADAPTER_STATS_EN
  logic [31:0] rd_count;
  logic [31:0] wr_count;
`endif

  line_burst_adapter dut (
    .clk      (clk),
    .rst      (rst),
    .bus      (bus.slave)
`ifdef LINE_ADAPTER_STATS_EN
    ,
    .rd_count (rd_count),
    .wr_count (wr_count)
`endif
  );

  typedef struct {
    logic         rd;
    logic         wr;
    logic [31:0]  addr;
    logic [255:0] line;
    logic [15:0]  gaps;
    logic [31:0]  exp_addr;
    logic [255:0] exp_line;
  } txn_t;

  txn_t vec [5];

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic checkOutput(input string name, input logic [255:0] actual, input logic [255:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s: got %0h expected %0h", name, actual, expected);
    end
  endtask

  // gaps: bit k is the resp_i value driven in the k-th burst cycle (beyond bit 15 always 1).
  task automatic applyStimulus(input txn_t t);
    int         b;
    int         k;
    logic       strobe;
    logic [2:0] exp_req;
    exp_req       = t.wr ? 3'b001 : 3'b010;
    bus.read_i    = t.rd;
    bus.write_i   = t.wr;
    bus.address_i = t.addr;
    bus.line_i    = t.line;
    @(negedge clk);
    checkOutput("address_o", {224'd0, bus.address_o}, {224'd0, t.exp_addr});
    bus.line_i    = ~t.line;
    bus.address_i = ~t.addr;
    b = 0;
    k = 0;
    while (b < 4 && k < 64) begin
      strobe      = (k < 16) ? t.gaps[k] : 1'b1;
      bus.resp_i  = strobe;
      bus.burst_i = strobe ? t.line[64*b +: 64] : 64'hBAD0_BAD0_BAD0_BAD0;
      checkOutput("req_hold", {253'd0, bus.resp_o, bus.read_o, bus.write_o}, {253'd0, exp_req});
      if (t.wr && strobe)
        checkOutput("burst_o", {192'd0, bus.burst_o}, {192'd0, t.line[64*b +: 64]});
      if (strobe) b++;
      k++;
      @(negedge clk);
    end
    if (b < 4) begin
      checks++;
      errors++;
      $display("[TB] FAIL burst_timeout: got %0d beats expected 4", b);
    end
    checkOutput("resp_pulse", {253'd0, bus.resp_o, bus.read_o, bus.write_o}, 256'd4);
    checkOutput("line_o", bus.line_o, t.exp_line);
    checkOutput("address_hold", {224'd0, bus.address_o}, {224'd0, t.exp_addr});
    bus.read_i  = 1'b0;
    bus.write_i = 1'b0;
    bus.resp_i  = 1'b1;
    bus.burst_i = 64'hDEAD_BEEF_DEAD_BEEF;
    @(negedge clk);
    checkOutput("resp_single", {253'd0, bus.resp_o, bus.read_o, bus.write_o}, 256'd0);
    checkOutput("line_o_hold", bus.line_o, t.exp_line);
    bus.resp_i = 1'b0;
  endtask

  initial begin
    checks = 0;
    errors = 0;

    vec[0] = '{rd: 1'b1, wr: 1'b0, addr: 32'h0000_1234,
               line: {64'h4444_4444_4444_4444, 64'h3333_3333_3333_3333,
                      64'h2222_2222_2222_2222, 64'h1111_1111_1111_1111},
               gaps: 16'hFFFF, exp_addr: 32'h0000_1220,
               exp_line: {64'h4444_4444_4444_4444, 64'h3333_3333_3333_3333,
                          64'h2222_2222_2222_2222, 64'h1111_1111_1111_1111}};
    vec[1] = '{rd: 1'b0, wr: 1'b1, addr: 32'h8000_00FF,
               line: {64'hDDDD_DDDD_DDDD_DDDD, 64'hCCCC_CCCC_CCCC_CCCC,
                      64'hBBBB_BBBB_BBBB_BBBB, 64'hAAAA_AAAA_AAAA_AAAA},
               gaps: 16'hFFFF, exp_addr: 32'h8000_00E0,
               exp_line: {64'h4444_4444_4444_4444, 64'h3333_3333_3333_3333,
                          64'h2222_2222_2222_2222, 64'h1111_1111_1111_1111}};
    vec[2] = '{rd: 1'b1, wr: 1'b0, addr: 32'h0000_0040,
               line: {64'h0123_4567_89AB_CDEF, 64'hFEDC_BA98_7654_3210,
                      64'h0F0F_0F0F_0F0F_0F0F, 64'hF0F0_F0F0_F0F0_F0F0},
               gaps: 16'hFF59, exp_addr: 32'h0000_0040,
               exp_line: {64'h0123_4567_89AB_CDEF, 64'hFEDC_BA98_7654_3210,
                          64'h0F0F_0F0F_0F0F_0F0F, 64'hF0F0_F0F0_F0F0_F0F0}};
    vec[3] = '{rd: 1'b1, wr: 1'b1, addr: 32'h0000_001F,
               line: {64'h5555_5555_5555_5555, 64'h6666_6666_6666_6666,
                      64'h7777_7777_7777_7777, 64'h8888_8888_8888_8888},
               gaps: 16'hFFF3, exp_addr: 32'h0000_0000,
               exp_line: {64'h0123_4567_89AB_CDEF, 64'hFEDC_BA98_7654_3210,
                          64'h0F0F_0F0F_0F0F_0F0F, 64'hF0F0_F0F0_F0F0_F0F0}};
    vec[4] = '{rd: 1'b1, wr: 1'b0, addr: 32'hFFFF_FFFF,
               line: {64'h9999_9999_9999_9999, 64'hAAAA_5555_AAAA_5555,
                      64'h1357_9BDF_2468_ACE0, 64'h0000_0000_0000_0001},
               gaps: 16'hFF6A, exp_addr: 32'hFFFF_FFE0,
               exp_line: {64'h9999_9999_9999_9999, 64'hAAAA_5555_AAAA_5555,
                          64'h1357_9BDF_2468_ACE0, 64'h0000_0000_0000_0001}};

    rst           = 1'b1;
    bus.line_i    = '0;
    bus.address_i = '0;
    bus.read_i    = 1'b0;
    bus.write_i   = 1'b0;
    bus.burst_i   = '0;
    bus.resp_i    = 1'b0;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    checkOutput("rst_resp_o", {255'd0, bus.resp_o}, 256'd0);
    checkOutput("rst_read_o", {255'd0, bus.read_o}, 256'd0);
    checkOutput("rst_write_o", {255'd0, bus.write_o}, 256'd0);
    checkOutput("rst_line_o", bus.line_o, 256'd0);
    checkOutput("rst_burst_o", {192'd0, bus.burst_o}, 256'd0);
    checkOutput("rst_address_o", {224'd0, bus.address_o}, 256'd0);

    // Read aborted by reset after two beats: no resp_o, outputs back to reset values.
    bus.read_i    = 1'b1;
    bus.address_i = 32'h0000_0100;
    @(negedge clk);
    checkOutput("abort_read_o", {255'd0, bus.read_o}, 256'd1);
    bus.resp_i  = 1'b1;
    bus.burst_i = 64'hA1A1_A1A1_A1A1_A1A1;
    @(negedge clk);
    bus.burst_i = 64'hB2B2_B2B2_B2B2_B2B2;
    @(negedge clk);
    bus.resp_i  = 1'b0;
    checkOutput("abort_partial_line",
                bus.line_o, {128'd0, 64'hB2B2_B2B2_B2B2_B2B2, 64'hA1A1_A1A1_A1A1_A1A1});
    rst         = 1'b1;
    bus.read_i  = 1'b0;
    @(negedge clk);
    rst = 1'b0;
    checkOutput("abort_flags", {253'd0, bus.resp_o, bus.read_o, bus.write_o}, 256'd0);
    checkOutput("abort_line_o", bus.line_o, 256'd0);
    checkOutput("abort_address_o", {224'd0, bus.address_o}, 256'd0);
    @(negedge clk);
    checkOutput("abort_idle", {253'd0, bus.resp_o, bus.read_o, bus.write_o}, 256'd0);
`ifdef LINE_ADAPTER_STATS_EN
    checkOutput("abort_rd_count", {224'd0, rd_count}, 256'd0);
`endif

    for (int i = 0; i < 5; i++) applyStimulus(vec[i]);

`ifdef LINE_ADAPTER_STATS_EN
    checkOutput("rd_count", {224'd0, rd_count}, 256'd3);
    checkOutput("wr_count", {224'd0, wr_count}, 256'd2);
`endif

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
